asa_riscv_muldiv_unit: RTL and testbench
========================================

ASA_RISCV_MULDIV_UNIT -- requirements
Module: asa_riscv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter MUL_STAGES, default 2, multiply latency in cycles; legal range 1..4.
REQ-003 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-004 SHALL have ports, clock and reset first:
  - clk  in  1  single clock; one clock; all state on rising edge.
  - rst  in  1  reset, synchronous and active-high.
  - valid_i  in  1  request valid from ID.
  - ready_o  out  1  unit can accept a request.
  - op_i  in  3  md_op_e operation.
  - operand_a_i  in  XLEN  rs1 value.
  - operand_b_i  in  XLEN  rs2 value.
  - tag_i  in  TAG_W  rd address.
  - flush_i  in  1  kill in-flight operation.
  - valid_o  out  1  result valid toward WB.
  - ready_i  in  1  WB can take result.
  - result_o  out  XLEN  result.
  - tag_o  out  TAG_W  rd address of result.
  - err_o  out  1  unsupported-op flag, qualified by valid_o.
  - busy_o  out  1  operation in flight (state != IDLE).

Function
REQ-005 SHALL use FSM states IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
REQ-006 SHALL drive ready_o = (state==IDLE) && !flush_i.
REQ-007 SHALL accept on a clk edge with valid_i && ready_o, capturing op, operands and tag; that edge is edge 0.
REQ-008 SHALL, for MUL/MULH/MULHSU/MULHU, assert valid_o after edge MUL_STAGES; MULHSU treats a as signed and b as unsigned.
REQ-009 SHALL, for DIV/DIVU/REM/REMU, take absolute values at accept, run a radix-2 restoring loop for XLEN DIV_ITER edges, apply sign correction in DIV_FIX, and assert valid_o after edge XLEN+1.
REQ-010 SHALL follow RISC-V sign rules: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-011 SHALL handle divisor zero on a fast path to DONE after edge 1: quotient all-ones, remainder = a.
REQ-012 SHALL handle signed overflow (a = most-negative, b = -1) on a fast path after edge 1: quotient = a, remainder = 0.
REQ-013 SHALL hold valid_o, result_o, tag_o and err_o stable in DONE until valid_o && ready_i, then go to IDLE, with ready_o high the next cycle.
REQ-014 SHALL, when flush_i is high in any state, go to IDLE at the next edge, deassert valid_o, and discard the result.
REQ-015 SHALL ignore valid_i in the same cycle as flush_i: no acceptance.
REQ-016 SHALL keep result_o/tag_o at their last values outside DONE; they are meaningful only with valid_o.

Reset
REQ-017 SHALL, with rst high at an edge, enter IDLE with valid_o=0, busy_o=0, err_o=0, result_o=0, tag_o=0, and iteration counter=0.
REQ-018 SHALL have rst abort any in-flight operation with no output pulse; rst has priority over flush_i and acceptance.

Configuration
REQ-019 SHALL include the divider when ASA_RV_DIV_EN is defined, with behaviour as in REQ-009..012; err_o is tied 0.
REQ-020 SHALL, when ASA_RV_DIV_EN is undefined (Zmmul), omit divider logic; divide ops complete after edge 1 with result_o=0 and err_o=1.

Structure
REQ-021 SHALL place md_op_e (MUL=0, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU=7) and the FSM state typedef in package asa_riscv_defines.
REQ-022 SHALL implement the divide datapath in sub-module asa_riscv_div_iter (counter, partial remainder, quotient shift register); the multiply stages are inline.

Verification
REQ-023 SHALL cover, with XLEN=32 and MUL_STAGES=2, multiplies with valid_o after edge 2:
  - MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB.
  - MULH 0x80000000 * 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-024 SHALL cover signed divide, valid_o after edge 33, tag 5'd9 echoed on tag_o:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
REQ-025 SHALL cover divide fast paths, valid_o after edge 1:
  - DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-026 SHALL cover backpressure: ready_i low for 5 cycles in DONE -> valid_o, result_o, tag_o stable and ready_o low; ready_i high -> IDLE next cycle.
REQ-027 SHALL cover flush_i at DIV_ITER cycle 10 -> no valid_o pulse, ready_o high next cycle, then MUL 3*4 -> 12.
REQ-028 SHALL cover the configuration without ASA_RV_DIV_EN: DIV 10/2 -> valid_o after edge 1, result_o=0, err_o=1; MUL still correct.

Source files
------------

// File: rtl/asa_riscv_defines.sv
// Shared types for the RISC-V M-extension multiply/divide unit: op encoding,
// FSM state encoding and small op-decode helpers.
package asa_riscv_defines;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_ITER = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } md_state_e;

  // Wide enough to count up to the deepest multiply latency (4).
  localparam int unsigned MUL_CNT_W = 2;

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_signed_div(input md_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op[2] && op[1];
  endfunction

endpackage

// File: rtl/asa_riscv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per
// enabled cycle, XLEN cycles per divide; o_last flags the final iteration.
module asa_riscv_div_iter
  import asa_riscv_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic            o_last
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;

  // Shift the next dividend bit into the partial remainder; borrow means restore.
  assign w_trial = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    end
  end

  assign o_quot = r_quo;
  assign o_rem  = r_rem;
  assign o_last = (r_cnt == CW'(XLEN - 1));

endmodule

// File: rtl/asa_riscv_muldiv_unit.sv
// RISC-V M-extension multiply/divide unit with valid/ready handshakes and flush.
// Define ASA_RV_DIV_EN to include the divider; otherwise divide ops return err_o (Zmmul).
module asa_riscv_muldiv_unit
  import asa_riscv_defines::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  operand_a_i,
  input  logic [XLEN-1:0]  operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int unsigned PW = 2 * XLEN;

  md_state_e             r_state;
  md_state_e             w_state_nxt;
  md_op_e                r_op;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_b;
  logic [TAG_W-1:0]      r_tag;
  logic [MUL_CNT_W-1:0]  r_mul_cnt;
  logic                  r_valid;
  logic [XLEN-1:0]       r_result;
  logic [TAG_W-1:0]      r_tag_out;
  logic                  r_err;

  md_op_e                w_op_in;
  logic                  w_accept;
  logic                  w_div_fast;
  logic                  w_div_last;
  logic                  w_load_out;
  logic [XLEN-1:0]       w_result_nxt;
  logic                  w_err_nxt;
  logic signed [XLEN:0]  w_mul_a;
  logic signed [XLEN:0]  w_mul_b;
  logic [PW-1:0]         w_prod;

  assign w_op_in  = md_op_e'(op_i);
  assign ready_o  = (r_state == ST_IDLE) && !flush_i;
  assign w_accept = valid_i && ready_o;
  assign busy_o   = (r_state != ST_IDLE);

  // a is signed for everything but MULHU; b only for MULH (MUL low half is sign-agnostic).
  assign w_mul_a = {(r_op != MULHU) && r_a[XLEN-1], r_a};
  assign w_mul_b = {(r_op == MULH) && r_b[XLEN-1], r_b};
  assign w_prod  = PW'(w_mul_a) * PW'(w_mul_b);

`ifdef ASA_RV_DIV_EN
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_div_start;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_div_res;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_zero;
  logic            r_ovf;

  assign w_a_neg     = md_is_signed_div(w_op_in) && operand_a_i[XLEN-1];
  assign w_b_neg     = md_is_signed_div(w_op_in) && operand_b_i[XLEN-1];
  assign w_abs_a     = w_a_neg ? -operand_a_i : operand_a_i;
  assign w_abs_b     = w_b_neg ? -operand_b_i : operand_b_i;
  assign w_b_zero    = (operand_b_i == '0);
  assign w_ovf       = md_is_signed_div(w_op_in) && (operand_b_i == '1)
                       && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}});
  assign w_div_fast  = w_b_zero || w_ovf;
  assign w_div_start = w_accept && md_is_div(w_op_in) && !w_div_fast;

  asa_riscv_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_en       (r_state == ST_DIV_ITER),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quo),
    .o_rem      (w_rem),
    .o_last     (w_div_last)
  );

  // Sign and fast-path flags are decided from the raw operands at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_zero  <= w_b_zero;
      r_ovf   <= w_ovf;
    end
  end

  always_comb begin
    w_div_res = '0;
    if (r_zero)                 w_div_res = md_is_rem(r_op) ? r_a : '1;
    else if (r_ovf)             w_div_res = md_is_rem(r_op) ? '0 : r_a;
    else if (md_is_rem(r_op))   w_div_res = r_neg_r ? -w_rem : w_rem;
    else                        w_div_res = r_neg_q ? -w_quo : w_quo;
  end
`else
  assign w_div_fast = 1'b1;
  assign w_div_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!md_is_div(w_op_in)) w_state_nxt = ST_MUL;
          else if (w_div_fast)     w_state_nxt = ST_DIV_FIX;
          else                     w_state_nxt = ST_DIV_ITER;
        end
      end
      ST_MUL:      if (r_mul_cnt == MUL_CNT_W'(MUL_STAGES - 1)) w_state_nxt = ST_DONE;
      ST_DIV_ITER: if (w_div_last) w_state_nxt = ST_DIV_FIX;
      ST_DIV_FIX:  w_state_nxt = ST_DONE;
      ST_DONE:     if (ready_i) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (flush_i) w_state_nxt = ST_IDLE;
  end

  // Result is latched only on the edge that enters DONE, so it holds afterwards.
  always_comb begin
    w_load_out   = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    w_result_nxt = '0;
    w_err_nxt    = 1'b0;
    if (r_state == ST_MUL) begin
      w_result_nxt = (r_op == MUL) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
    end else begin
`ifdef ASA_RV_DIV_EN
      w_result_nxt = w_div_res;
`else
      w_err_nxt    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_tag     <= '0;
      r_mul_cnt <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_tag_out <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op_in;
        r_a   <= operand_a_i;
        r_b   <= operand_b_i;
        r_tag <= tag_i;
      end
      r_mul_cnt <= (r_state == ST_MUL) ? r_mul_cnt + MUL_CNT_W'(1) : '0;
      r_valid   <= (w_state_nxt == ST_DONE);
      if (w_load_out) begin
        r_result  <= w_result_nxt;
        r_tag_out <= r_tag;
        r_err     <= w_err_nxt;
      end
    end
  end

  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign tag_o    = r_tag_out;
  assign err_o    = r_err;

endmodule

// File: tb/tb_asa_riscv_muldiv_unit.sv
// Scoreboard bench for asa_riscv_muldiv_unit: directed vectors, flush/reset/backpressure
// scenarios and randomized ops against an arithmetic reference model.
module tb_asa_riscv_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MS   = 2;
  localparam int unsigned TW   = 5;
`ifdef ASA_RV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [2:0]      op_i = 3'd0;
  logic [XLEN-1:0] operand_a_i = '0;
  logic [XLEN-1:0] operand_b_i = '0;
  logic [TW-1:0]   tag_i = '0;
  logic            flush_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] result_o;
  logic [TW-1:0]   tag_o;
  logic            err_o;
  logic            busy_o;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp_rand = 1'b0;
  logic bp_level = 1'b1;
  bit   have_cur = 1'b0;
  logic [31:0] h_res;
  logic [4:0]  h_tag;
  logic        h_err;

  asa_riscv_muldiv_unit #(
    .XLEN(XLEN), .MUL_STAGES(MS), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .tag_i(tag_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .tag_o(tag_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    ready_i = bp_rand ? ($urandom_range(0, 3) != 0) : bp_level;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour from the ISA definition using plain 64-bit arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    exp_t r;
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    int          ia = $signed(a);
    int          ib = $signed(b);
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r.tag = tag;
    r.err = 1'b0;
    r.acc = 0;
    r.lat = MS;
    r.res = '0;
    case (op)
      3'd0: begin p = sa * sb; r.res = p[31:0];  end
      3'd1: begin p = sa * sb; r.res = p[63:32]; end
      3'd2: begin p = sa * ub; r.res = p[63:32]; end
      3'd3: begin p = ua * ub; r.res = p[63:32]; end
      default: begin
        if (!DIV_EN) begin
          r.lat = 1;
          r.err = 1'b1;
        end else if (b == 0) begin
          r.lat = 1;
          r.res = (op == 3'd6 || op == 3'd7) ? a : 32'hFFFF_FFFF;
        end else if (ovf && (op == 3'd4 || op == 3'd6)) begin
          r.lat = 1;
          r.res = (op == 3'd4) ? a : 32'd0;
        end else begin
          r.lat = XLEN + 1;
          case (op)
            3'd4:    r.res = 32'(ia / ib);
            3'd5:    r.res = a / b;
            3'd6:    r.res = 32'(ia % ib);
            default: r.res = a % b;
          endcase
        end
      end
    endcase
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (!ready_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready_o stayed %0b for %0d cycles", ready_o, n);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit expect_out);
    exp_t e;
    wait_ready();
    valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; tag_i = tag;
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (expect_out) begin
      e = model(op, a, b, tag);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!valid_o && n < 100);
    chk(name, valid_o, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop on the first cycle of each result, then check it holds.
  always @(negedge clk) begin
    if (rst || !valid_o) begin
      have_cur = 1'b0;
    end else begin
      if (!have_cur) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %0h tag %0d with nothing expected",
                   result_o, tag_o);
        end else begin
          mon_e = q.pop_front();
          chk("result", result_o, mon_e.res);
          chk("tag", tag_o, mon_e.tag);
          chk("err", err_o, mon_e.err);
          chk("latency", cyc - mon_e.acc, mon_e.lat);
        end
        h_res = result_o; h_tag = tag_o; h_err = err_o;
        have_cur = 1'b1;
      end else begin
        chk("hold_result", result_o, h_res);
        chk("hold_tag", tag_o, h_tag);
        chk("hold_err", err_o, h_err);
        chk("ready_o_in_done", ready_o, 1'b0);
      end
      if (ready_i) have_cur = 1'b0;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    chk("rst_result_o", result_o, 32'd0);
    chk("rst_tag_o", tag_o, 5'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_o", ready_o, 1'b1);

    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 1'b1);
    issue(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd9, 1'b1);
    issue(3'd5, 32'd100,        32'd0,         5'd5, 1'b1);
    issue(3'd7, 32'd100,        32'd0,         5'd6, 1'b1);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7, 1'b1);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 1'b1);
    issue(3'd4, 32'd10,         32'd2,         5'd10, 1'b1);
    issue(3'd0, 32'd10,         32'd2,         5'd11, 1'b1);

    // Backpressure: hold the result for 5 cycles.
    wait_ready();
    bp_level = 1'b0;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
    wait_valid("bp_valid_seen");
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_ready_o_low", ready_o, 1'b0);
      chk("bp_valid_held", valid_o, 1'b1);
    end
    bp_level = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("bp_release_ready_o", ready_o, 1'b1);
    chk("bp_release_valid_o", valid_o, 1'b0);

    // Flush an in-flight divide, then a multiply must still work.
    issue(3'd4, 32'd1000, 32'd7, 5'd11, 1'b0);
    if (DIV_EN) begin
      repeat (9) @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    #1;
    chk("flush_ready_o_low", ready_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("flush_ready_next", ready_o, 1'b1);
    chk("flush_busy_next", busy_o, 1'b0);
    chk("flush_valid_next", valid_o, 1'b0);
    repeat (4) @(posedge clk);
    issue(3'd0, 32'd3, 32'd4, 5'd12, 1'b1);

    // valid_i together with flush_i must not be accepted.
    wait_ready();
    valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd5; operand_b_i = 32'd5; tag_i = 5'd13;
    flush_i = 1'b1;
    #1;
    chk("flush_valid_ready_o", ready_o, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_valid_not_busy", busy_o, 1'b0);

    // Flush while the result is waiting in DONE discards it.
    bp_level = 1'b0;
    issue(3'd0, 32'd5, 32'd6, 5'd14, 1'b1);
    wait_valid("done_flush_valid_seen");
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("done_flush_valid_o", valid_o, 1'b0);
    chk("done_flush_ready_o", ready_o, 1'b1);
    chk("done_flush_result_kept", result_o, 32'd30);
    bp_level = 1'b1;

    // Reset aborts an in-flight op and beats a simultaneous request.
    issue(3'd1, 32'd123, 32'd456, 5'd15, 1'b0);
    rst = 1'b1;
    valid_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_i = 1'b0;
    chk("midrst_valid_o", valid_o, 1'b0);
    chk("midrst_busy_o", busy_o, 1'b0);
    chk("midrst_result_o", result_o, 32'd0);
    chk("midrst_tag_o", tag_o, 5'd0);
    repeat (4) @(posedge clk);

    // Randomized ops with random backpressure.
    bp_rand = 1'b1;
    repeat (80) issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'b1);

    n = 0;
    while ((q.size() != 0 || busy_o) && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    bp_rand = 1'b0;
    chk("drain_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
